avmm_arbiter_m: RTL and testbench

//   Round-robin arbiter that shares one AVMM slave between N AVMM masters, e.g. a DMA engine and a

---
 rtl/avmm_arbiter_m.sv | 178 +++++++++++++++++
 tb/tb_avmm_arbiter_m.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/avmm_arbiter_m.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | avmm_arbiter_m : round-robin AVMM arbiter, grant held per whole transaction|
// | Rev 1.0                                                                     |
// +---------------------------------------------------------------------------+
module avmm_arbiter_m #(
  parameter int N         = 2,
  parameter int AW        = 16,
  parameter int DW        = 32,
  parameter int MAX_BURST = 1,
  parameter int BW        = $clog2(MAX_BURST) + 1,
  parameter int GW        = $clog2(N)
) (
  input  logic                        clk,
  input  logic                        rst,
  // requester side, one lane per master
  input  logic [N-1:0][AW-1:0]        i_m_address,
  input  logic [N-1:0][BW-1:0]        i_m_burstcount,
  input  logic [N-1:0][DW/8-1:0]      i_m_byteenable,
  input  logic [N-1:0][DW-1:0]        i_m_writedata,
  input  logic [N-1:0]                i_m_read,
  input  logic [N-1:0]                i_m_write,
  output logic [N-1:0]                o_m_waitrequest,
  output logic [N-1:0][DW-1:0]        o_m_readdata,
  output logic [N-1:0]                o_m_readdatavalid,
  // shared slave side
  output logic [AW-1:0]               o_s_address,
  output logic [BW-1:0]               o_s_burstcount,
  output logic [DW/8-1:0]             o_s_byteenable,
  output logic [DW-1:0]               o_s_writedata,
  output logic                        o_s_read,
  output logic                        o_s_write,
  input  logic                        i_s_waitrequest,
  input  logic [DW-1:0]               i_s_readdata,
  input  logic                        i_s_readdatavalid,
  output logic                        busy,
  output logic [GW-1:0]               grant_id
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WRITE   = 2'd1,
    ST_RD_CMD  = 2'd2,
    ST_RD_DATA = 2'd3
  } state_t;

  state_t        r_state;
  logic [GW-1:0] r_grant;
  logic [GW-1:0] r_ptr;
  logic [BW-1:0] r_cnt;
  logic [BW-1:0] r_beats;
  logic          r_busy;

  logic [N-1:0]  w_req;
  logic          w_found;
  logic [GW-1:0] w_pick;
  logic [GW:0]   w_idx;
  logic [BW-1:0] w_bc;
  logic [BW-1:0] w_beats_new;
  logic          w_last;
  logic [GW-1:0] w_ptr_next;
  logic          w_active;

  assign w_req = i_m_read | i_m_write;

  // First requester at or after the pointer; sum stays below 2N so one wrap suffices.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_idx   = '0;
    for (int k = 0; k < N; k++) begin
      w_idx = {1'b0, r_ptr} + (GW+1)'(k);
      if (w_idx >= (GW+1)'(N))
        w_idx = w_idx - (GW+1)'(N);
      if (!w_found && w_req[w_idx[GW-1:0]]) begin
        w_found = 1'b1;
        w_pick  = w_idx[GW-1:0];
      end
    end
  end

  assign w_bc        = i_m_burstcount[w_pick];
  assign w_beats_new = (w_bc == '0) ? BW'(1) : w_bc;
  assign w_last      = (r_cnt == r_beats - BW'(1));
  assign w_ptr_next  = (r_grant == GW'(N-1)) ? '0 : r_grant + GW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_beats <= '0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_grant <= w_pick;
            r_beats <= w_beats_new;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= i_m_write[w_pick] ? ST_WRITE : ST_RD_CMD;
          end
        end
        ST_WRITE: begin
          if (i_m_write[r_grant] && !i_s_waitrequest) begin
            if (w_last) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
              r_ptr   <= w_ptr_next;
            end else begin
              r_cnt <= r_cnt + BW'(1);
            end
          end
        end
        ST_RD_CMD: begin
          // A valid beat can arrive in the same cycle the command is accepted.
          if (i_s_readdatavalid && w_last) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_ptr   <= w_ptr_next;
          end else begin
            if (i_s_readdatavalid)
              r_cnt <= r_cnt + BW'(1);
            if (i_m_read[r_grant] && !i_s_waitrequest)
              r_state <= ST_RD_DATA;
          end
        end
        ST_RD_DATA: begin
          if (i_s_readdatavalid) begin
            if (w_last) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
              r_ptr   <= w_ptr_next;
            end else begin
              r_cnt <= r_cnt + BW'(1);
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Routing is gated by rst so nothing from the slave leaks out during reset.
  assign w_active = (r_state != ST_IDLE) && !rst;
  assign busy     = r_busy && !rst;
  assign grant_id = r_grant;

  always_comb begin
    o_s_address       = '0;
    o_s_burstcount    = '0;
    o_s_byteenable    = '0;
    o_s_writedata     = '0;
    o_s_read          = 1'b0;
    o_s_write         = 1'b0;
    o_m_waitrequest   = '1;
    o_m_readdata      = '0;
    o_m_readdatavalid = '0;
    if (w_active) begin
      o_s_address                = i_m_address[r_grant];
      o_s_burstcount             = i_m_burstcount[r_grant];
      o_s_byteenable             = i_m_byteenable[r_grant];
      o_s_writedata              = i_m_writedata[r_grant];
      o_s_write                  = (r_state == ST_WRITE) && i_m_write[r_grant];
      o_s_read                   = (r_state == ST_RD_CMD) && i_m_read[r_grant];
      o_m_waitrequest[r_grant]   = (r_state == ST_RD_DATA) ? 1'b1 : i_s_waitrequest;
      o_m_readdata[r_grant]      = i_s_readdata;
      o_m_readdatavalid[r_grant] = i_s_readdatavalid;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_avmm_arbiter_m.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_avmm_arbiter_m : random stimulus vs transaction-level arbiter model     |
// | Rev 1.0                                                                     |
// +---------------------------------------------------------------------------+
module tb_avmm_arbiter_m;
  localparam int N  = 3;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int MB = 4;
  localparam int BW = $clog2(MB) + 1;
  localparam int GW = $clog2(N);

  logic                   clk = 1'b0;
  logic                   rst;
  logic [N-1:0][AW-1:0]   m_address;
  logic [N-1:0][BW-1:0]   m_burstcount;
  logic [N-1:0][DW/8-1:0] m_byteenable;
  logic [N-1:0][DW-1:0]   m_writedata;
  logic [N-1:0]           m_read;
  logic [N-1:0]           m_write;
  logic [N-1:0]           m_waitrequest;
  logic [N-1:0][DW-1:0]   m_readdata;
  logic [N-1:0]           m_readdatavalid;
  logic [AW-1:0]          s_address;
  logic [BW-1:0]          s_burstcount;
  logic [DW/8-1:0]        s_byteenable;
  logic [DW-1:0]          s_writedata;
  logic                   s_read;
  logic                   s_write;
  logic                   s_waitrequest;
  logic [DW-1:0]          s_readdata;
  logic                   s_readdatavalid;
  logic                   busy;
  logic [GW-1:0]          grant_id;

  avmm_arbiter_m #(.N(N), .AW(AW), .DW(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst),
    .i_m_address(m_address), .i_m_burstcount(m_burstcount),
    .i_m_byteenable(m_byteenable), .i_m_writedata(m_writedata),
    .i_m_read(m_read), .i_m_write(m_write),
    .o_m_waitrequest(m_waitrequest), .o_m_readdata(m_readdata),
    .o_m_readdatavalid(m_readdatavalid),
    .o_s_address(s_address), .o_s_burstcount(s_burstcount),
    .o_s_byteenable(s_byteenable), .o_s_writedata(s_writedata),
    .o_s_read(s_read), .o_s_write(s_write),
    .i_s_waitrequest(s_waitrequest), .i_s_readdata(s_readdata),
    .i_s_readdatavalid(s_readdatavalid),
    .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Transaction-level model: who owns the slave, what kind, beats done vs beats owed.
  int md_busy, md_owner, md_is_wr, md_cmd_sent, md_beats, md_done, md_ptr, md_gid;
  int idx, bc, found, grants;

  logic [N-1:0]         e_wait;
  logic [N-1:0]         e_rdv;
  logic [N-1:0][DW-1:0] e_rdata;

  task automatic model_reset();
    md_busy = 0; md_owner = 0; md_is_wr = 0; md_cmd_sent = 0;
    md_beats = 0; md_done = 0; md_ptr = 0; md_gid = 0;
  endtask

  task automatic check_outputs();
    e_wait  = '1;
    e_rdv   = '0;
    e_rdata = '0;
    if (rst || md_busy == 0) begin
      chk("s_read", s_read, 0);
      chk("s_write", s_write, 0);
      chk("busy", busy, 0);
    end else begin
      chk("s_write", s_write, (md_is_wr != 0) && m_write[md_owner]);
      chk("s_read", s_read, (md_is_wr == 0) && (md_cmd_sent == 0) && m_read[md_owner]);
      chk("busy", busy, 1);
      chk("s_address", s_address, m_address[md_owner]);
      chk("s_burstcount", s_burstcount, m_burstcount[md_owner]);
      chk("s_byteenable", s_byteenable, m_byteenable[md_owner]);
      chk("s_writedata", s_writedata, m_writedata[md_owner]);
      e_wait[md_owner]  = ((md_is_wr == 0) && (md_cmd_sent != 0)) ? 1'b1 : s_waitrequest;
      e_rdv[md_owner]   = s_readdatavalid;
      e_rdata[md_owner] = s_readdata;
    end
    chk("m_waitrequest", m_waitrequest, e_wait);
    chk("m_readdatavalid", m_readdatavalid, e_rdv);
    chk("m_readdata", m_readdata, e_rdata);
    if (!rst) chk("grant_id", grant_id, md_gid);
  endtask

  task automatic model_step();
    if (rst) begin
      model_reset();
    end else if (md_busy == 0) begin
      found = 0;
      for (int k = 0; k < N; k++) begin
        idx = (md_ptr + k) % N;
        if (found == 0 && (m_read[idx] || m_write[idx])) begin
          found       = 1;
          md_busy     = 1;
          md_owner    = idx;
          md_gid      = idx;
          md_is_wr    = m_write[idx] ? 1 : 0;
          md_cmd_sent = 0;
          bc          = int'(m_burstcount[idx]);
          md_beats    = (bc == 0) ? 1 : bc;
          md_done     = 0;
          grants++;
        end
      end
    end else begin
      if (md_is_wr != 0) begin
        if (m_write[md_owner] && !s_waitrequest) md_done++;
      end else begin
        if (s_readdatavalid) md_done++;
        if (md_cmd_sent == 0 && m_read[md_owner] && !s_waitrequest) md_cmd_sent = 1;
      end
      if (md_done >= md_beats) begin
        md_busy = 0;
        md_ptr  = (md_owner + 1) % N;
      end
    end
  endtask

  task automatic drive_random(input int req_pct, input int rst_pct);
    rst = ($urandom_range(0, 999) < rst_pct);
    for (int i = 0; i < N; i++) begin
      m_address[i]    = AW'($urandom);
      m_burstcount[i] = BW'($urandom_range(0, MB));
      m_byteenable[i] = (DW/8)'($urandom);
      m_writedata[i]  = $urandom;
      m_read[i]       = ($urandom_range(0, 99) < req_pct);
      m_write[i]      = ($urandom_range(0, 99) < req_pct);
    end
    s_waitrequest   = $urandom_range(0, 1) == 1;
    s_readdatavalid = $urandom_range(0, 2) == 0;
    s_readdata      = $urandom;
  endtask

  initial begin
    grants = 0;
    rst = 1'b1;
    m_address = '0; m_burstcount = '0; m_byteenable = '0; m_writedata = '0;
    m_read = '0; m_write = '0;
    s_waitrequest = 1'b0; s_readdata = '0; s_readdatavalid = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    // Slave activity during reset must not reach any master.
    s_readdatavalid = 1'b1;
    s_readdata      = 32'hDEAD_BEEF;
    #1;
    check_outputs();
    @(negedge clk);
    rst = 1'b0;
    s_readdatavalid = 1'b0;
    #1;
    check_outputs();
    chk("grant_id_reset", grant_id, 0);

    // Random phases: busy contention, sparse requests, and occasional mid-flight resets.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      if (cyc < 1500)      drive_random(40, 5);
      else if (cyc < 2500) drive_random(10, 0);
      else                 drive_random(70, 15);
      #1;
      check_outputs();
      model_step();
    end

    chk("grants_seen", (grants > 100) ? 1 : 0, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
